// File: rtl/rotary_input_filter_if.sv
// Encoder pin bundle: raw A/B in, filtered levels and edge pulses out.
// NEGROTAF exists only when ROT_FALL_PULSE_EN is defined.
interface rotary_input_filter_if;
  logic ROTA;
  logic ROTB;
  logic ROTAF;
  logic ROTBF;
  logic POSROTAF;
`ifdef ROT_FALL_PULSE_EN
  logic NEGROTAF;
`endif

  modport master (
    output ROTA, ROTB,
    input  ROTAF, ROTBF, POSROTAF
`ifdef ROT_FALL_PULSE_EN
    , input NEGROTAF
`endif
  );

  modport slave (
    input  ROTA, ROTB,
    output ROTAF, ROTBF, POSROTAF
`ifdef ROT_FALL_PULSE_EN
    , output NEGROTAF
`endif
  );
endinterface

// File: rtl/rotary_input_filter.sv
// Rotary encoder front end: 2-flop sync + per-channel debounce, A rise pulse.
// Optional ROT_FALL_PULSE_EN adds a registered A fall pulse (NEGROTAF).
module rotary_input_filter_chan #(
  parameter int DEB_CYCLES = 5000,
  parameter int CNT_W      = 13
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic filt,
  output logic flip
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEB_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  // High in the cycle the filtered level is about to adopt the synced level.
  assign flip = (s2 != filt) && (cnt == TERM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (flip) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module rotary_input_filter #(
  parameter int DEB_CYCLES = 5000,
  parameter int CNT_W      = 13
) (
  input logic                 CLK,
  input logic                 RST,
  rotary_input_filter_if.slave rot
);
  logic [1:0] raw, filt, flip;
  logic       pos;

  assign raw = {rot.ROTB, rot.ROTA};

  rotary_input_filter_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan [1:0] (
    .CLK  (CLK),
    .RST  (RST),
    .raw  (raw),
    .filt (filt),
    .flip (flip)
  );

  // B edges carry no pulse; downstream only samples ROTBF on the A rise.
  logic unused_flip_b;
  assign unused_flip_b = flip[1];

`ifdef ROT_FALL_PULSE_EN
  logic neg;
  always_ff @(posedge CLK) begin
    if (RST) begin
      pos <= 1'b0;
      neg <= 1'b0;
    end else begin
      pos <= flip[0] & ~filt[0];
      neg <= flip[0] &  filt[0];
    end
  end
  assign rot.NEGROTAF = neg;
`else
  always_ff @(posedge CLK) begin
    if (RST) pos <= 1'b0;
    else     pos <= flip[0] & ~filt[0];
  end
`endif

  assign rot.ROTAF    = filt[0];
  assign rot.ROTBF    = filt[1];
  assign rot.POSROTAF = pos;
endmodule

// File: tb/tb_rotary_input_filter.sv
// Scoreboard bench: window-based reference model predicts outputs per edge,
// a negedge monitor compares; directed phases follow the encoder use cases.
module tb_rotary_input_filter;
  localparam int DEB = 4;
  localparam int CW  = 13;

  typedef struct packed {
    logic af;
    logic bf;
    logic pos;
    logic neg;
  } obs_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  rotary_input_filter_if rot();

  rotary_input_filter #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .rot (rot.slave)
  );

  always #5 CLK = ~CLK;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   pos_cnt = 0;
  logic pos_bf[$];
  obs_t exp_q[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, req, $time);
  endtask

  // Reference: a level is adopted once the last DEB delayed samples seen since
  // the previous change all differ from the current filtered level.
  initial begin : model
    logic dly[2][$];
    logic samp[2][$];
    logic [1:0] filt;
    logic [1:0] raw;
    logic v, ok;
    obs_t o;
    filt = 2'b00;
    forever begin
      @(posedge CLK);
      raw = {rot.ROTB, rot.ROTA};
      o = '0;
      if (RST) begin
        for (int c = 0; c < 2; c++) begin
          dly[c].delete();
          dly[c].push_back(1'b0);
          dly[c].push_back(1'b0);
          samp[c].delete();
        end
        filt = 2'b00;
      end else begin
        for (int c = 0; c < 2; c++) begin
          v = dly[c].pop_front();
          dly[c].push_back(raw[c]);
          samp[c].push_back(v);
          if (samp[c].size() > DEB) void'(samp[c].pop_front());
          ok = (samp[c].size() == DEB);
          foreach (samp[c][i]) if (samp[c][i] == filt[c]) ok = 1'b0;
          if (ok) begin
            if (c == 0) begin
              o.pos = v;
              o.neg = ~v;
            end
            filt[c] = v;
            samp[c].delete();
          end
        end
      end
      o.af = filt[0];
      o.bf = filt[1];
      exp_q.push_back(o);
    end
  end

  initial begin : monitor
    obs_t e, g;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.af  = rot.ROTAF;
        g.bf  = rot.ROTBF;
        g.pos = rot.POSROTAF;
`ifdef ROT_FALL_PULSE_EN
        g.neg = rot.NEGROTAF;
`else
        g.neg = 1'b0;
        e.neg = 1'b0;
`endif
        check("outputs{af,bf,pos,neg}", g, e);
        if (g.pos === 1'b1) begin
          pos_cnt++;
          pos_bf.push_back(rot.ROTBF);
        end
      end
    end
  end

  task automatic drive(input logic a, input logic b, input int n);
    @(negedge CLK);
    rot.ROTA = a;
    rot.ROTB = b;
    repeat (n - 1) @(negedge CLK);
    #1;
  endtask

  initial begin : stim
    int base;
    logic [1:0] cw_ph[4];
    logic [1:0] ccw_ph[4];
    cw_ph  = '{2'b01, 2'b11, 2'b10, 2'b00};  // {B,A}
    ccw_ph = '{2'b10, 2'b11, 2'b01, 2'b00};
    rot.ROTA = 1'b1;
    rot.ROTB = 1'b1;

    // Reset held with pins high, then release: one pulse after normal latency.
    repeat (3) @(negedge CLK);
    #1;
    check("reset_af_bf_pos", {rot.ROTAF, rot.ROTBF, rot.POSROTAF}, 3'b000);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 1'b1, 12);
    check("reset_release_pulses", 4'(pos_cnt), 4'd1);
    check("reset_release_af", {3'b0, rot.ROTAF}, 4'd1);

    // Fall, then bounce 3-cycle highs, then steady high.
    base = pos_cnt;
    drive(1'b0, 1'b1, 12);
    check("fall_no_pos", 4'(pos_cnt - base), 4'd0);
    check("fall_af", {3'b0, rot.ROTAF}, 4'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 3);
      drive(1'b0, 1'b1, 3);
    end
    check("bounce_no_pos", 4'(pos_cnt - base), 4'd0);
    drive(1'b1, 1'b1, 12);
    check("bounce_then_steady", 4'(pos_cnt - base), 4'd1);
    check("steady_bf_held", {3'b0, rot.ROTBF}, 4'd1);

    // Reset mid-count discards the count and emits no pulse.
    drive(1'b0, 1'b0, 12);
    base = pos_cnt;
    drive(1'b1, 1'b0, 4);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    check("midcount_rst_outs", {1'b0, rot.ROTAF, rot.ROTBF, rot.POSROTAF}, 4'd0);
    RST = 1'b0;
    drive(1'b1, 1'b0, 12);
    check("midcount_release_pulse", 4'(pos_cnt - base), 4'd1);

    // Quadrature: 4 CW then 4 CCW detents.
    drive(1'b0, 1'b0, 12);
    base = pos_cnt;
    pos_bf.delete();
    for (int d = 0; d < 4; d++)
      for (int p = 0; p < 4; p++) drive(cw_ph[p][0], cw_ph[p][1], 10 * DEB);
    for (int d = 0; d < 4; d++)
      for (int p = 0; p < 4; p++) drive(ccw_ph[p][0], ccw_ph[p][1], 10 * DEB);
    check("quad_pulse_count", 4'(pos_cnt - base), 4'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < pos_bf.size())
        check($sformatf("quad_bf_at_pulse%0d", i), {3'b0, pos_bf[i]}, (i < 4) ? 4'd0 : 4'd1);
      else
        check($sformatf("quad_bf_at_pulse%0d", i), 4'hf, (i < 4) ? 4'd0 : 4'd1);
    end

    // Random bouncy traffic with occasional resets, checked by the model.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end
      drive(1'($urandom), 1'($urandom), int'($urandom_range(1, 8)));
    end

    drive(1'b0, 1'b0, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
